// File: rtl/inport_requester_if.sv
// inport_requester_if: upstream flit, arbiter request/grant and crossbar head-flit signals of one router input port
interface inport_requester_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH = 4
);
  logic in_valid;
  logic [FLIT_WIDTH-1:0] in_flit;
  logic in_ready;
  logic [2:0] request_bundle;
  logic grant;
  logic [FLIT_WIDTH-1:0] out_flit;
  logic [$clog2(DEPTH):0] fifo_count;
  modport master (
    output in_valid, in_flit, grant,
    input in_ready, request_bundle, out_flit, fifo_count
  );
  modport slave (
    input in_valid, in_flit, grant,
    output in_ready, request_bundle, out_flit, fifo_count
  );
endinterface

// File: rtl/inport_requester.sv
// inport_requester: flit FIFO plus IDLE/ROUTE/REQUEST FSM that raises a stable {hit_x,hit_y,request} bundle until granted
module inport_requester #(
  parameter int FLIT_WIDTH = 32,
  parameter int ADDR_W = 2,
  parameter int X_LOCAL = 0,
  parameter int Y_LOCAL = 0,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  inport_requester_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, ROUTE, REQUEST} state_t;
  state_t r_state, w_state_nxt;
  logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count, w_count_nxt;
  logic r_hit_x, r_hit_y;
  logic w_push, w_pop, w_full, w_req;
  logic [FLIT_WIDTH-1:0] w_head;
  assign w_head = r_mem[r_rptr];
  assign w_full = r_count == CW'(DEPTH);
  assign w_req = r_state == REQUEST;
  assign w_push = bus.in_valid & ~w_full;
  assign w_pop = bus.grant & w_req;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = r_state == IDLE ? (r_count != '0 ? ROUTE : IDLE) :
                  r_state == ROUTE ? REQUEST :
                  !w_pop ? REQUEST :
                  w_count_nxt != '0 ? ROUTE : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      r_hit_x <= 1'b0;
      r_hit_y <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (r_state == ROUTE) begin
        r_hit_x <= w_head[FLIT_WIDTH-1 -: ADDR_W] == ADDR_W'(X_LOCAL);
        r_hit_y <= w_head[FLIT_WIDTH-ADDR_W-1 -: ADDR_W] == ADDR_W'(Y_LOCAL);
      end
    end
  end
  // storage needs no reset: contents are only observed while request is high
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.in_flit;
  end
  assign bus.in_ready = ~w_full;
  assign bus.request_bundle = {w_req & r_hit_x, w_req & r_hit_y, w_req};
  assign bus.out_flit = w_head;
  assign bus.fifo_count = r_count;
endmodule
